// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array feeder.
// Sized for a 3x3 output-stationary MAC array.
package systolic_pkg;
    localparam int N           = 3;
    localparam int LOAD_BEATS  = 2 * N * N;
    localparam int FEED_CYCLES = 2 * N - 1;
    localparam int DATA_W_DEF  = 8;
    localparam int AW          = $clog2(LOAD_BEATS);

    typedef enum logic [2:0] {
        LOAD,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_e;
endpackage

// File: rtl/feeder_buffer.sv
// Holds A (entries 0..8) and B (entries 9..17), row-major.
// Single write port, all entries readable at once for the skew mux.
import systolic_pkg::*;

module feeder_buffer #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  we,
    input  logic [AW-1:0]                         waddr,
    input  logic [DATA_W-1:0]                     wdata,
    output logic [LOAD_BEATS-1:0][DATA_W-1:0]     mem
);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/systolic_feeder.sv
// Loads A then B over a valid/ready stream, then drives the skewed
// wavefront into a 3x3 systolic MAC array, flushes, and pulses done.
import systolic_pkg::*;

module systolic_feeder #(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              acc_clr,
    output logic              feed_valid,
    output logic [DATA_W-1:0] row0,
    output logic [DATA_W-1:0] row1,
    output logic [DATA_W-1:0] row2,
    output logic [DATA_W-1:0] col0,
    output logic [DATA_W-1:0] col1,
    output logic [DATA_W-1:0] col2,
    output logic              busy,
    output logic              done
);

    state_e                               state;
    logic [7:0]                           cnt;
    logic                                 we;
    logic [LOAD_BEATS-1:0][DATA_W-1:0]    mem;
    logic [N-1:0][DATA_W-1:0]             row_q;
    logic [N-1:0][DATA_W-1:0]             col_q;
    logic [N-1:0][DATA_W-1:0]             nxt_row;
    logic [N-1:0][DATA_W-1:0]             nxt_col;

    assign we = (state == LOAD) && in_valid;

    feeder_buffer #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (cnt[AW-1:0]),
        .wdata (in_data),
        .mem   (mem)
    );

    // Wavefront k = cnt: row i carries A[i][k-i], column j carries B[k-j][j].
    always_comb begin
        nxt_row = '0;
        nxt_col = '0;
        for (int i = 0; i < N; i++) begin
            for (int t = 0; t < N; t++) begin
                if (int'(cnt) == i + t) begin
                    nxt_row[i] = mem[i*N + t];
                    nxt_col[i] = mem[N*N + t*N + i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            cnt        <= '0;
            in_ready   <= 1'b1;
            acc_clr    <= 1'b0;
            feed_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (cnt == 8'(LOAD_BEATS - 1)) begin
                            cnt      <= '0;
                            state    <= CLEAR;
                            in_ready <= 1'b0;
                            acc_clr  <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                CLEAR: begin
                    row_q      <= nxt_row;
                    col_q      <= nxt_col;
                    feed_valid <= 1'b1;
                    cnt        <= 8'd1;
                    state      <= FEED;
                end
                FEED: begin
                    if (cnt == 8'(FEED_CYCLES)) begin
                        row_q      <= '0;
                        col_q      <= '0;
                        feed_valid <= 1'b0;
                        cnt        <= '0;
                        if (FLUSH_CYCLES == 0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        row_q <= nxt_row;
                        col_q <= nxt_col;
                        cnt   <= cnt + 8'd1;
                    end
                end
                FLUSH: begin
                    if (32'(cnt) == FLUSH_CYCLES - 1) begin
                        cnt   <= '0;
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    in_ready <= 1'b1;
                    state    <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign row0 = row_q[0];
    assign row1 = row_q[1];
    assign row2 = row_q[2];
    assign col0 = col_q[0];
    assign col1 = col_q[1];
    assign col2 = col_q[2];

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream stage for the 3x3 systolic MAC array.
- Accepts A and B element-by-element over a valid/ready stream and buffers both matrices.
- Pulses an accumulator clear, then drives the skewed row/column wavefront into the array's three row inputs and three column inputs, zero-flushes, and signals done.
- Replaces hard-wired per-element matrix ports with a reusable load-then-feed sequencer.

Parameters:
- DATA_W, 8, element width of A, B and all feed outputs.
- FLUSH_CYCLES, 2, zero cycles driven after the last wavefront so the far-corner MAC settles before done.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a valid element.
- in_ready  out  1  feeder can accept an element.
- in_data  in  DATA_W  element. Order: A row-major (a00..a22), then B row-major (b00..b22); 18 beats total.
- acc_clr  out  1  one-cycle pulse clearing all array accumulators before feeding.
- feed_valid  out  1  row/col outputs carry a wavefront cycle.
- row0, row1, row2  out  DATA_W each  array row inputs (Rin[0..2]).
- col0, col1, col2  out  DATA_W each  array column inputs (Cin[0..2]).
- busy  out  1  high in CLEAR, FEED, FLUSH.
- done  out  1  one-cycle pulse when array results are final.

Behaviour:
- Reset: all outputs 0 except in_ready=1. State LOAD, beat counter 0, buffer contents don't-care. Reset asserted mid-FEED/FLUSH aborts immediately: row/col go 0 on the next edge and no done pulse occurs.
- States: LOAD, CLEAR, FEED, FLUSH, DONE.
- LOAD:
  - in_ready=1. A beat is accepted when in_valid && in_ready at a rising edge.
  - Beat index 0..8 writes A[idx/3][idx%3]; index 9..17 writes B[(idx-9)/3][(idx-9)%3].
  - After the 18th accept (index 17): counter -> 0, next state CLEAR.
  - in_valid low stalls with no change.
- CLEAR: exactly 1 cycle. acc_clr=1, in_ready=0, row/col=0, feed_valid=0. Next state FEED.
- FEED: 5 cycles, k=0..4. feed_valid=1. All outputs are registered.
  - row_i = A[i][k-i] if 0<=k-i<=2, else 0.
  - col_j = B[k-j][j] if 0<=k-j<=2, else 0.
  - k=0: row=(a00,0,0), col=(b00,0,0).
  - k=2: row=(a02,a11,a20), col=(b20,b11,b02).
  - k=4: row=(0,0,a22), col=(0,0,b22).
  - After k=4: next state FLUSH.
- FLUSH: FLUSH_CYCLES cycles of row/col=0, feed_valid=0. Next state DONE.
- DONE: 1 cycle. done=1, busy=0, in_ready=0. Next state LOAD, ready for a new matrix pair.
- in_ready=0 in all states except LOAD. in_valid in other states is ignored and does not corrupt the buffer.
- Latency: the edge accepting beat 17 is edge E0. Then:
  - acc_clr is high in cycle E0+1.
  - FEED occupies E0+2..E0+6.
  - FLUSH occupies E0+7..E0+6+FLUSH_CYCLES.
  - done is high in cycle E0+7+FLUSH_CYCLES (E0+9 at default).
- Buffer is written only in LOAD, so values are stable throughout FEED.
- No arithmetic in this block; values pass through unmodified at DATA_W bits.

Decomposition:
- Shared package systolic_pkg:
  - N=3, LOAD_BEATS=2*N*N, FEED_CYCLES=2*N-1.
  - State enum {LOAD, CLEAR, FEED, FLUSH, DONE}.
  - DATA_W default.
- One sub-module, feeder_buffer: 18-entry DATA_W register file with a single write port and combinational read of all 18 entries. The skew mux and FSM stay in systolic_feeder.

Test Plan:
- Reset then 18 beats with A=1..9 and B=identity, in_valid held high -> accepts on 18 consecutive edges. acc_clr on the next cycle. FEED cycle k=2 shows row=(3,5,7), col=(0,1,0). done 9 cycles after the last accept.
- Same data with in_valid toggled every other cycle -> exactly 18 accepts, identical FEED sequence, no extra writes.
- in_valid=1 with in_data=0xFF throughout CLEAR/FEED/FLUSH -> in_ready=0, outputs unaffected. The next LOAD starts at index 0.
- rst pulsed during FEED k=3 -> next cycle row/col=0, feed_valid=0, in_ready=1, no done. A following full load runs correctly.
- Back-to-back: the second matrix pair is loaded immediately after done -> second FEED reflects only the new data.
- Connect to the 3x3 MAC array: A=all 2, B=all 3 -> after done, every array output equals 18 (0x12).
